// File: rtl/jtpopeye_objscan_pkg.sv
// Shared definitions for the object line scanner: sprite entry layout,
// DJ descriptor field positions and scanner FSM encoding.
package jtpopeye_objscan_pkg;

    localparam logic [1:0] BYTE_X    = 2'd0;
    localparam logic [1:0] BYTE_Y    = 2'd1;
    localparam logic [1:0] BYTE_CODE = 2'd2;
    localparam logic [1:0] BYTE_ATTR = 2'd3;

    localparam int DJ_W          = 18;
    localparam int DJ_ROW_LSB    = 0;
    localparam int DJ_CODE_LSB   = 4;
    localparam int DJ_HFLIP      = 11;
    localparam int DJ_CSTART_LSB = 12;
    localparam int DJ_PAL_LSB    = 14;
    localparam int DJ_CODE7      = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_FETCH = 2'd2,
        ST_EVAL  = 2'd3
    } scan_state_t;

    // byte2 = {hflip, code[6:0]}, byte3 = {pal[2:0], code[7], xx, cstart[1:0]}
    function automatic logic [DJ_W-1:0] pack_dj(
        input logic [3:0] row,
        input logic [7:0] code_byte,
        input logic [7:0] attr_byte
    );
        logic [DJ_W-1:0] dj;
        dj = '0;
        dj[DJ_ROW_LSB    +: 4] = row;
        dj[DJ_CODE_LSB   +: 7] = code_byte[6:0];
        dj[DJ_HFLIP]           = code_byte[7];
        dj[DJ_CSTART_LSB +: 2] = attr_byte[1:0];
        dj[DJ_PAL_LSB    +: 3] = attr_byte[7:5];
        dj[DJ_CODE7]           = attr_byte[4];
        return dj;
    endfunction

endpackage

// File: rtl/jtpopeye_objlbuf.sv
// Double-buffered object line buffer: 2 banks x 64 slots of DJ descriptors,
// one write port on wbank, one read port on the opposite bank.
module jtpopeye_objlbuf
    import jtpopeye_objscan_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wbank,
    input  logic            clr,
    input  logic            we,
    input  logic [5:0]      waddr,
    input  logic [DJ_W-1:0] wdata,
    output logic            wvalid,
    input  logic [5:0]      raddr,
    output logic [DJ_W-1:0] rdata
);

    logic [1:0][63:0] valid;
    logic [DJ_W-1:0]  mem [0:127];
    logic             rbank;

    assign rbank  = ~wbank;
    assign wvalid = valid[wbank][waddr];

    // Payload needs no reset: the valid vector gates every read.
    always_ff @(posedge clk) begin
        if (we) mem[{wbank, waddr}] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clr) begin
            valid[wbank] <= '0;
        end else if (we) begin
            valid[wbank][waddr] <= 1'b1;
        end
    end

    assign rdata = valid[rbank][raddr] ? mem[{rbank, raddr}] : '0;

endmodule

// File: rtl/jtpopeye_objscan.sv
// Object line scanner: walks sprite RAM each line, stores hitting objects'
// descriptors into the back bank and plays the front bank out on DJ.
module jtpopeye_objscan
    import jtpopeye_objscan_pkg::*;
#(
    parameter int OBJ_NUM = 64,
    parameter int OBJ_H   = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic        line_start,
    input  logic [7:0]  V,
    input  logic [7:0]  H,
    input  logic        HB,
    input  logic        VB,
    input  logic        RV_n,
    output logic        obj_ram_cs,
    output logic [7:0]  obj_ram_addr,
    input  logic [7:0]  obj_ram_data,
    output logic [17:0] DJ,
    output logic        scan_busy
);

    localparam logic [5:0] LAST = 6'(OBJ_NUM - 1);

    scan_state_t     state, state_nxt;
    logic [5:0]      entry;
    logic [1:0]      bsel;
    logic            wbank;
    logic [7:0]      vline, x_q, y_q, code_q;
    logic [7:0]      row;
    logic            hit, clr, we, wvalid;
    logic [DJ_W-1:0] wdata, rdata;
    logic [5:0]      raddr;
    logic            unused;

    assign unused = ^{H[1:0], x_q[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // line_start wins in every state: a running scan is abandoned
    always_comb begin
        state_nxt = state;
        if (line_start) begin
            state_nxt = ST_CLR;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_CLR:   state_nxt = ST_FETCH;
                ST_FETCH: if (bsel == BYTE_ATTR) state_nxt = ST_EVAL;
                ST_EVAL:  state_nxt = (entry == LAST) ? ST_IDLE : ST_FETCH;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        obj_ram_cs   = 1'b0;
        obj_ram_addr = 8'd0;
        clr          = 1'b0;
        we           = 1'b0;
        case (state)
            ST_CLR:   clr = ~line_start;
            ST_FETCH: begin
                obj_ram_cs   = 1'b1;
                obj_ram_addr = {entry, bsel};
            end
            ST_EVAL:  we = hit & ~wvalid & ~line_start;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank  <= 1'b0;
            entry  <= 6'd0;
            bsel   <= 2'd0;
            vline  <= 8'd0;
            x_q    <= 8'd0;
            y_q    <= 8'd0;
            code_q <= 8'd0;
        end else if (line_start) begin
            wbank <= ~wbank;
            vline <= V;
        end else begin
            case (state)
                ST_CLR: begin
                    entry <= 6'd0;
                    bsel  <= 2'd0;
                end
                ST_FETCH: begin
                    bsel <= bsel + 2'd1;
                    // RAM data lags the address by one clk
                    case (bsel)
                        BYTE_Y:    x_q    <= obj_ram_data;
                        BYTE_CODE: y_q    <= obj_ram_data;
                        BYTE_ATTR: code_q <= obj_ram_data;
                        default: ;
                    endcase
                end
                ST_EVAL: entry <= entry + 6'd1;
                default: ;
            endcase
        end
    end

    assign row   = vline - y_q;
    assign hit   = row < 8'(OBJ_H);
    assign wdata = pack_dj(row[3:0], code_q, obj_ram_data);
    assign raddr = RV_n ? H[7:2] : ~H[7:2];

    jtpopeye_objlbuf u_lbuf (
        .clk    (clk),
        .rst_n  (rst_n),
        .wbank  (wbank),
        .clr    (clr),
        .we     (we),
        .waddr  (x_q[7:2]),
        .wdata  (wdata),
        .wvalid (wvalid),
        .raddr  (raddr),
        .rdata  (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       DJ <= '0;
        else if (pxl_cen) DJ <= (HB || VB) ? '0 : rdata;
    end

    assign scan_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_jtpopeye_objscan.sv
// Directed bench for the object line scanner: hit, priority, wrap, flip,
// blanking, abort and reset behaviour against hand-computed descriptors.
module tb_jtpopeye_objscan;

    logic        clk = 1'b0, rst_n = 1'b0, pxl_cen = 1'b1, line_start = 1'b0;
    logic        HB = 1'b0, VB = 1'b0, RV_n = 1'b1;
    logic [7:0]  V = 8'd0, H = 8'd0, obj_ram_data = 8'd0;
    logic        obj_ram_cs, scan_busy;
    logic [7:0]  obj_ram_addr;
    logic [17:0] DJ;
    logic [7:0]  ram [0:255];
    int          n_chk = 0, n_err = 0;

    jtpopeye_objscan dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .line_start(line_start),
        .V(V), .H(H), .HB(HB), .VB(VB), .RV_n(RV_n),
        .obj_ram_cs(obj_ram_cs), .obj_ram_addr(obj_ram_addr),
        .obj_ram_data(obj_ram_data), .DJ(DJ), .scan_busy(scan_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) obj_ram_data <= ram[obj_ram_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse();
        line_start = 1'b1; tick(); line_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (scan_busy && n < 400) begin tick(); n++; end
    endtask

    // Y=0xC0 misses for every V used here
    task automatic ram_clear();
        for (int i = 0; i < 64; i++) begin
            ram[4*i] = 8'h00; ram[4*i+1] = 8'hC0; ram[4*i+2] = 8'h00; ram[4*i+3] = 8'h00;
        end
    endtask

    task automatic set_obj(input int idx, input logic [7:0] x, y, b2, b3);
        ram[4*idx] = x; ram[4*idx+1] = y; ram[4*idx+2] = b2; ram[4*idx+3] = b3;
    endtask

    // scan one line, then swap so it becomes the played-out bank
    task automatic scan_line(input logic [7:0] v);
        int n;
        V = v; pulse(); wait_idle(n);
        chk("scan_len", n, 321);
        pulse();
    endtask

    task automatic rd(input string tag, input logic [7:0] h, input logic [17:0] exp);
        H = h; tick();
        chk(tag, DJ, exp);
    endtask

    initial begin
        int n;
        ram_clear();
        repeat (3) tick();
        chk("rst_dj", DJ, 0);
        chk("rst_cs", obj_ram_cs, 0);
        chk("rst_addr", obj_ram_addr, 0);
        chk("rst_busy", scan_busy, 0);
        rst_n = 1'b1; tick();

        // row 3, code 0x05, hflip, cstart 3, pal 5
        set_obj(0, 8'h40, 8'h10, 8'h85, 8'hA3);
        scan_line(8'h13);
        rd("hit_h40", 8'h40, 18'h17853);
        rd("hit_h43", 8'h43, 18'h17853);
        rd("miss_h3c", 8'h3C, 18'h0);
        rd("miss_h44", 8'h44, 18'h0);
        rd("miss_h00", 8'h00, 18'h0);
        RV_n = 1'b0;
        rd("flip_hbc", 8'hBC, 18'h17853);
        rd("flip_h40", 8'h40, 18'h0);
        HB = 1'b1; rd("hb_blank", 8'hBC, 18'h0); HB = 1'b0;
        VB = 1'b1; rd("vb_blank", 8'hBC, 18'h0); VB = 1'b0;
        RV_n = 1'b1;

        ram_clear();
        set_obj(2, 8'h80, 8'h10, 8'h11, 8'h00);
        set_obj(7, 8'h80, 8'h10, 8'h22, 8'h00);
        set_obj(9, 8'hC0, 8'h10, 8'h7F, 8'h1C);
        scan_line(8'h13);
        rd("prio_h80", 8'h80, 18'h00113);
        rd("code7_hc0", 8'hC0, 18'h207F3);
        rd("cleared_h40", 8'h40, 18'h0);

        ram_clear();
        set_obj(5, 8'h20, 8'hFA, 8'h01, 8'h00);
        scan_line(8'h03);
        rd("ywrap_row9", 8'h20, 18'h00019);
        set_obj(5, 8'h20, 8'h10, 8'h01, 8'h00);
        scan_line(8'h1F);
        rd("row15_hit", 8'h20, 18'h0001F);
        scan_line(8'h20);
        rd("row16_miss", 8'h20, 18'h0);

        ram_clear();
        set_obj(0, 8'h00, 8'h10, 8'h01, 8'h00);
        set_obj(63, 8'hFC, 8'h10, 8'h02, 8'h00);
        V = 8'h13; pulse();
        repeat (99) tick();
        chk("abort_busy_pre", scan_busy, 1);
        pulse();
        chk("abort_busy_post", scan_busy, 1);
        wait_idle(n);
        chk("abort_len", n, 321);
        rd("abort_e0", 8'h00, 18'h00013);
        rd("abort_e63_lost", 8'hFC, 18'h0);
        pulse();
        rd("full_e63", 8'hFC, 18'h00023);
        rd("full_e0", 8'h00, 18'h00013);

        pulse();
        repeat (9) tick();
        chk("fetch_cs", obj_ram_cs, 1);
        chk("fetch_addr", obj_ram_addr, 8'h07);
        rst_n = 1'b0; #1;
        chk("rst_mid_cs", obj_ram_cs, 0);
        chk("rst_mid_busy", scan_busy, 0);
        chk("rst_mid_dj", DJ, 0);
        tick(); rst_n = 1'b1;
        rd("post_rst_h00", 8'h00, 18'h0);
        rd("post_rst_hfc", 8'hFC, 18'h0);
        scan_line(8'h13);
        rd("post_rst_scan", 8'h00, 18'h00013);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
